// File: rtl/eq_pkg.sv
// Shared types and level arithmetic for the equalizer level/enter initiator.
// Levels are 5-bit signed; intermediate arithmetic uses one extra bit.
package eq_pkg;

    localparam int LEVEL_W = 5;
    localparam int WIDE_W  = LEVEL_W + 1;

    typedef logic signed [LEVEL_W-1:0] level_t;

    typedef enum logic [1:0] {
        BAND_BASS = 2'd0,
        BAND_MID  = 2'd1,
        BAND_TREB = 2'd2
    } band_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        PULSE   = 2'd2,
        RECOVER = 2'd3
    } state_e;

    // Band selection wraps 0->1->2->0; code 3 is never produced.
    function automatic band_e next_band(input band_e b);
        case (b)
            BAND_BASS: return BAND_MID;
            BAND_MID:  return BAND_TREB;
            default:   return BAND_BASS;
        endcase
    endfunction

    // Step by +/-1 in a wider signed domain so the clamp sees the true value.
    function automatic level_t step_level(input level_t cur, input logic up,
                                          input int lmax, input int lmin);
        logic signed [WIDE_W-1:0] wide;
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi   = WIDE_W'(lmax);
        lo   = WIDE_W'(lmin);
        wide = {cur[LEVEL_W-1], cur};
        wide = up ? (wide + WIDE_W'(1)) : (wide - WIDE_W'(1));
        if (wide > hi) begin
            wide = hi;
        end
        if (wide < lo) begin
            wide = lo;
        end
        return level_t'(wide[LEVEL_W-1:0]);
    endfunction

endpackage

// File: rtl/eq_btn_debounce.sv
// One raw push button: 2-flop synchronizer, stability counter and a one-cycle
// press pulse on an accepted 0->1 transition (releases produce no pulse).
module eq_btn_debounce
    import eq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          stable;
    logic [CW-1:0] cnt;

    // cnt counts consecutive samples that disagree with the accepted level;
    // the last of DEBOUNCE_CYCLES such samples flips the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_b;
                cnt    <= '0;
                press  <= sync_b;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/eq_level_ctrl.sv
// Equalizer level/enter initiator: debounced buttons edit three saturating band
// levels and an apply drives a clean active-low enter strobe. EQ_AUTO_APPLY_EN
// makes level edits and reset release start an apply sequence automatically.
module eq_level_ctrl
    import eq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 50000,
    parameter int ENTER_LOW_CYCLES = 4,
    parameter int LEVEL_MAX        = 15,
    parameter int LEVEL_MIN        = -15,
    parameter int LEVEL_DEFAULT    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_next,
    input  logic       btn_apply,
    output level_t     bass_level,
    output level_t     mid_level,
    output level_t     treble_level,
    output logic       enter,
    output logic [1:0] band_sel,
    output logic       busy,
    output state_e     fsm_state
);

`ifdef EQ_AUTO_APPLY_EN
    localparam bit AUTO_APPLY = 1'b1;
`else
    localparam bit AUTO_APPLY = 1'b0;
`endif

    localparam int CW = (ENTER_LOW_CYCLES > 1) ? $clog2(ENTER_LOW_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ENTER_LOW_CYCLES - 1);
    localparam level_t LEVEL_RST = level_t'(LEVEL_DEFAULT);

    logic press_up;
    logic press_down;
    logic press_next;
    logic press_apply;

    eq_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .rst_n(rst_n), .raw(btn_up), .press(press_up)
    );
    eq_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .rst_n(rst_n), .raw(btn_down), .press(press_down)
    );
    eq_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk(clk), .rst_n(rst_n), .raw(btn_next), .press(press_next)
    );
    eq_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_apply (
        .clk(clk), .rst_n(rst_n), .raw(btn_apply), .press(press_apply)
    );

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    band_e         band_q, band_d;
    level_t        bass_q, bass_d;
    level_t        mid_q, mid_d;
    level_t        treb_q, treb_d;
    logic          pend_q, pend_d;
    logic          enter_q;

    level_t sel_level;
    level_t stepped;
    logic   level_change;

    always_comb begin
        case (band_q)
            BAND_MID:  sel_level = mid_q;
            BAND_TREB: sel_level = treb_q;
            default:   sel_level = bass_q;
        endcase
    end

    // up together with down cancels; a saturated step is not a change.
    assign stepped      = step_level(sel_level, press_up, LEVEL_MAX, LEVEL_MIN);
    assign level_change = (press_up ^ press_down) && (stepped != sel_level);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        band_d  = band_q;
        bass_d  = bass_q;
        mid_d   = mid_q;
        treb_d  = treb_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (press_apply || pend_q) begin
                    state_d = SETUP;
                    pend_d  = 1'b0;
                end else if (press_next) begin
                    band_d = next_band(band_q);
                end else if (level_change) begin
                    case (band_q)
                        BAND_MID:  mid_d  = stepped;
                        BAND_TREB: treb_d = stepped;
                        default:   bass_d = stepped;
                    endcase
                    pend_d = AUTO_APPLY;
                end
            end
            SETUP: begin
                state_d = PULSE;
                cnt_d   = '0;
            end
            PULSE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RECOVER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RECOVER: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // enter is registered from the next state so it is low exactly in PULSE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            band_q  <= BAND_BASS;
            bass_q  <= LEVEL_RST;
            mid_q   <= LEVEL_RST;
            treb_q  <= LEVEL_RST;
            pend_q  <= AUTO_APPLY;
            enter_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            band_q  <= band_d;
            bass_q  <= bass_d;
            mid_q   <= mid_d;
            treb_q  <= treb_d;
            pend_q  <= pend_d;
            enter_q <= (state_d != PULSE);
        end
    end

    assign bass_level   = bass_q;
    assign mid_level    = mid_q;
    assign treble_level = treb_q;
    assign enter        = enter_q;
    assign band_sel     = band_q;
    assign busy         = (state_q != IDLE);
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_eq_level_ctrl.sv
// Bench for eq_level_ctrl: directed scenarios plus random button traffic,
// scored against a band/level model through expected-response queues.
module tb_eq_level_ctrl;
    import eq_pkg::*;

    localparam int DEB     = 4;
    localparam int ELOW    = 4;
    localparam int SEQ_LEN = 1 + 2 * ELOW;
    localparam int GAP     = 16;
`ifdef EQ_AUTO_APPLY_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam logic [16:0] RESET_SNAP = {2'd0, 5'd3, 5'd3, 5'd3};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_apply = 1'b0;
    level_t     bass_level;
    level_t     mid_level;
    level_t     treble_level;
    logic       enter;
    logic [1:0] band_sel;
    logic       busy;
    state_e     fsm_state;

    eq_level_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .ENTER_LOW_CYCLES(ELOW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_next    (btn_next),
        .btn_apply   (btn_apply),
        .bass_level  (bass_level),
        .mid_level   (mid_level),
        .treble_level(treble_level),
        .enter       (enter),
        .band_sel    (band_sel),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_vec = 0;
    int n_err = 0;
    logic [16:0] exp_q[$];
    logic [14:0] exp_seq_q[$];
    int lvl[3];
    int band;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // reference model
    function automatic logic [14:0] lvl_snap();
        return {5'(lvl[2]), 5'(lvl[1]), 5'(lvl[0])};
    endfunction

    function automatic logic [16:0] full_snap();
        return {2'(band), lvl_snap()};
    endfunction

    function automatic logic [16:0] dut_snap();
        return {band_sel, treble_level, mid_level, bass_level};
    endfunction

    function automatic void model_reset();
        lvl  = '{3, 3, 3};
        band = 0;
    endfunction

    // mask bits: 0 up, 1 down, 2 next, 3 apply
    function automatic void model_press(input logic [3:0] mask);
        int nv;
        if (mask[3]) begin
            exp_seq_q.push_back(lvl_snap());
        end else if (mask[2]) begin
            band = (band + 1) % 3;
            exp_q.push_back(full_snap());
        end else if (mask[0] != mask[1]) begin
            nv = lvl[band] + (mask[0] ? 1 : -1);
            if (nv > 15) nv = 15;
            if (nv < -15) nv = -15;
            if (nv != lvl[band]) begin
                lvl[band] = nv;
                exp_q.push_back(full_snap());
                if (AUTO) exp_seq_q.push_back(lvl_snap());
            end
        end
    endfunction

    // driver tasks
    task automatic set_btns(input logic [3:0] m);
        btn_up    = m[0];
        btn_down  = m[1];
        btn_next  = m[2];
        btn_apply = m[3];
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        if (hold >= DEB) model_press(mask);
        @(posedge clk);
        #1;
        set_btns(mask);
        repeat (hold) @(posedge clk);
        #1;
        set_btns(4'b0000);
        repeat (GAP) @(posedge clk);
    endtask

    // which: 0 busy, 1 enter
    task automatic wait_sig(input int which, input logic val, input int lim, input string name);
        int i;
        for (i = 0; i < lim; i++) begin
            if (((which == 0) ? busy : enter) === val) break;
            @(posedge clk);
            #1;
        end
        check(name, (i < lim), 1);
    endtask

    // monitor / scoreboard
    logic [16:0] last_snap = RESET_SNAP;
    logic [16:0] cur_snap;
    logic [14:0] fall_snap = '0;
    logic        busy_prev = 1'b0;
    logic        enter_prev = 1'b1;
    int          busy_cnt = 0;
    int          low_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_snap  = RESET_SNAP;
            busy_prev  = 1'b0;
            enter_prev = 1'b1;
            busy_cnt   = 0;
            low_cnt    = 0;
        end else begin
            cur_snap = dut_snap();
            if (cur_snap !== last_snap) begin
                if (exp_q.size() == 0) check("unexpected_change", cur_snap, last_snap);
                else check("snapshot", cur_snap, exp_q.pop_front());
                last_snap = cur_snap;
            end
            if (busy && !busy_prev) begin
                busy_cnt = 0;
                low_cnt  = 0;
            end
            if (busy) busy_cnt++;
            if (!enter) begin
                low_cnt++;
                if (!busy) check("enter_low_while_idle", busy, 1);
            end
            if (!enter && enter_prev) fall_snap = cur_snap[14:0];
            if (!busy && busy_prev) begin
                if (exp_seq_q.size() == 0) begin
                    check("unexpected_apply", busy_cnt, 0);
                end else begin
                    check("busy_width", busy_cnt, SEQ_LEN);
                    check("enter_low_width", low_cnt, ELOW);
                    check("levels_at_enter_fall", fall_snap, exp_seq_q.pop_front());
                end
            end
            busy_prev  = busy;
            enter_prev = enter;
        end
    end

    // stimulus
    initial begin
        int lows;
        int hold;
        int r;
        logic [3:0] mask;

        model_reset();
        set_btns(4'b0000);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_levels", dut_snap(), RESET_SNAP);
        check("rst_enter", enter, 1);
        check("rst_busy", busy, 0);
        check("rst_state", fsm_state, IDLE);
        if (AUTO) exp_seq_q.push_back(lvl_snap());
        rst_n = 1'b1;
        repeat (GAP + 4) @(posedge clk);

        // bass up to saturation
        repeat (13) press(4'b0001, 5);
        check("bass_saturated", dut_snap(), full_snap());

        // band stepping, then mid down to saturation
        repeat (3) press(4'b0100, 5);
        check("band_wrap", band_sel, 0);
        press(4'b0100, 6);
        repeat (20) press(4'b0010, 4);
        check("mid_saturated", dut_snap(), full_snap());

        // simultaneous presses: up+down cancel, apply beats next, next beats up
        press(4'b0011, 5);
        press(4'b1100, 5);
        press(4'b0101, 5);
        check("priority", dut_snap(), full_snap());
        press(4'b0100, 5);
        press(4'b0100, 5);

        // apply with an up press landing while busy
        model_press(4'b1000);
        @(posedge clk);
        #1;
        set_btns(4'b1000);
        repeat (5) @(posedge clk);
        #1;
        set_btns(4'b0000);
        wait_sig(0, 1'b1, 20, "busy_rise_timeout");
        set_btns(4'b0001);
        repeat (5) @(posedge clk);
        #1;
        set_btns(4'b0000);
        wait_sig(0, 1'b0, 30, "busy_fall_timeout");
        repeat (GAP) @(posedge clk);
        check("press_during_busy_dropped", dut_snap(), full_snap());

        // glitch shorter than debounce, then a proper hold
        press(4'b0001, 3);
        check("glitch_ignored", dut_snap(), full_snap());
        press(4'b0001, 6);
        check("held_increment", dut_snap(), full_snap());

        // reset in the second PULSE cycle
        model_press(4'b1000);
        @(posedge clk);
        #1;
        set_btns(4'b1000);
        repeat (5) @(posedge clk);
        #1;
        set_btns(4'b0000);
        wait_sig(1, 1'b0, 20, "enter_fall_timeout");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midseq_rst_enter", enter, 1);
        check("midseq_rst_levels", {bass_level, mid_level, treble_level}, {5'd3, 5'd3, 5'd3});
        check("midseq_rst_busy", busy, 0);
        exp_seq_q.delete();
        model_reset();
        if (AUTO) exp_seq_q.push_back(lvl_snap());
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!enter) lows++;
        end
        check("post_reset_low_cycles", lows, AUTO ? ELOW : 0);

        // random traffic
        for (int k = 0; k < 60; k++) begin
            r    = $urandom_range(0, 19);
            hold = $urandom_range(DEB, DEB + 4);
            if (r < 7) mask = 4'b0001;
            else if (r < 14) mask = 4'b0010;
            else if (r < 16) mask = 4'b0100;
            else if (r < 18) begin
                mask = 4'(1 << $urandom_range(0, 3));
                hold = $urandom_range(1, DEB - 1);
            end else mask = 4'b1000;
            press(mask, hold);
        end
        check("random_final", dut_snap(), full_snap());

        repeat (GAP) @(posedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("exp_seq_q_drained", exp_seq_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
